// File: rtl/ct_lsu_dcache_tag_ctrl.sv
// Dcache tag SRAM front end: sweeps zeros through every tag index after reset or on
// an invalidate-all request, and grants single-cycle LSU accesses the rest of the time.
module ct_lsu_dcache_tag_ctrl #(
  parameter int INDEX_W = 9,
  parameter int DEPTH   = 512
) (
  input  logic               cpuclk,
  input  logic               cpurst_b,
  input  logic               inv_req,
  output logic               inv_busy,
  output logic               inv_done,
  input  logic               acc_vld,
  input  logic               acc_wr,
  input  logic [INDEX_W-1:0] acc_idx,
  input  logic [1:0]         acc_way_wen,
  input  logic [51:0]        acc_din,
  output logic               acc_grnt,
  output logic               rd_vld,
  output logic [INDEX_W-1:0] tag_idx,
  output logic               tag_sel_b,
  output logic               tag_gwen_b,
  output logic [1:0]         tag_wen_b,
  output logic [51:0]        tag_din,
  output logic               tag_gateclk_en,
  output logic [0:0]         dbg_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);
  localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);

  generate
    if (DEPTH < 1 || DEPTH > (1 << INDEX_W)) begin : g_bad_depth
      $error("ct_lsu_dcache_tag_ctrl: DEPTH must be in 1..2**INDEX_W");
    end
  endgenerate

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [INDEX_W-1:0] cnt;
  logic [INDEX_W-1:0] cnt_nxt;
  logic               init_sweep;
  logic               init_sweep_nxt;
  logic               inv_done_nxt;
  logic               rd_vld_nxt;
  logic               in_sweep;
  logic               sweep_last;
  logic               acc_wr_any;

  assign in_sweep   = (state == SWEEP);
  assign sweep_last = in_sweep && (cnt == LAST_IDX);
  assign acc_wr_any = acc_wr & (|acc_way_wen);

  // Handshakes: acc_vld is a request that is accepted in the same cycle acc_grnt is
  // high (no buffering, the requester retries otherwise); inv_req is a level held by
  // the requester until it observes the single-cycle inv_done pulse.
  assign acc_grnt  = ~in_sweep & ~inv_req & acc_vld;
  assign inv_busy  = in_sweep;
  assign dbg_state = state;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    init_sweep_nxt = init_sweep;
    inv_done_nxt   = 1'b0;
    case (state)
      SWEEP: begin
        if (sweep_last) begin
          state_nxt      = IDLE;
          cnt_nxt        = '0;
          init_sweep_nxt = 1'b0;
          // Only a requested sweep reports completion; the power-on sweep is silent.
          inv_done_nxt   = ~init_sweep;
        end else begin
          cnt_nxt = cnt + IDX_ONE;
        end
      end
      IDLE: begin
        if (inv_req) begin
          state_nxt      = SWEEP;
          cnt_nxt        = '0;
          init_sweep_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = SWEEP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The SRAM returns read data one cycle after the select, so rd_vld trails the grant.
  assign rd_vld_nxt = acc_grnt & ~acc_wr;

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state      <= SWEEP;
      cnt        <= '0;
      init_sweep <= 1'b1;
      inv_done   <= 1'b0;
      rd_vld     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      init_sweep <= init_sweep_nxt;
      inv_done   <= inv_done_nxt;
      rd_vld     <= rd_vld_nxt;
    end
  end

  always_comb begin
    tag_idx        = acc_idx;
    tag_din        = acc_din;
    tag_sel_b      = 1'b1;
    tag_gwen_b     = 1'b1;
    tag_wen_b      = 2'b11;
    tag_gateclk_en = 1'b0;
    if (in_sweep) begin
      tag_idx        = cnt;
      tag_din        = '0;
      tag_sel_b      = 1'b0;
      tag_gwen_b     = 1'b0;
      tag_wen_b      = 2'b00;
      tag_gateclk_en = 1'b1;
    end else if (acc_grnt) begin
      // A write with an empty way mask keeps gwen_b high and behaves as a read.
      tag_sel_b      = 1'b0;
      tag_gwen_b     = ~acc_wr_any;
      tag_wen_b      = ~acc_way_wen;
      tag_gateclk_en = 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_lsu_dcache_tag_ctrl.sv
// Bench for ct_lsu_dcache_tag_ctrl: a DEPTH=512 and a DEPTH=256 instance share stimulus
// and are compared every cycle against a sweep/grant model, plus directed literal checks.
module tb_ct_lsu_dcache_tag_ctrl;

  localparam int IW = 9;

  logic          cpuclk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          inv_req = 1'b0;
  logic          acc_vld = 1'b0;
  logic          acc_wr = 1'b0;
  logic [IW-1:0] acc_idx = '0;
  logic [1:0]    acc_way_wen = 2'b00;
  logic [51:0]   acc_din = '0;

  logic          o_busy[2];
  logic          o_done[2];
  logic          o_grnt[2];
  logic          o_rdv[2];
  logic [IW-1:0] o_idx[2];
  logic          o_sel[2];
  logic          o_gwen[2];
  logic [1:0]    o_wen[2];
  logic [51:0]   o_din[2];
  logic          o_gate[2];
  logic [0:0]    o_state[2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 cpuclk = ~cpuclk;

  ct_lsu_dcache_tag_ctrl #(.INDEX_W(IW), .DEPTH(512)) u_dut512 (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .inv_req(inv_req),
    .inv_busy(o_busy[0]), .inv_done(o_done[0]),
    .acc_vld(acc_vld), .acc_wr(acc_wr), .acc_idx(acc_idx),
    .acc_way_wen(acc_way_wen), .acc_din(acc_din),
    .acc_grnt(o_grnt[0]), .rd_vld(o_rdv[0]), .tag_idx(o_idx[0]),
    .tag_sel_b(o_sel[0]), .tag_gwen_b(o_gwen[0]), .tag_wen_b(o_wen[0]),
    .tag_din(o_din[0]), .tag_gateclk_en(o_gate[0]), .dbg_state(o_state[0])
  );

  ct_lsu_dcache_tag_ctrl #(.INDEX_W(IW), .DEPTH(256)) u_dut256 (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .inv_req(inv_req),
    .inv_busy(o_busy[1]), .inv_done(o_done[1]),
    .acc_vld(acc_vld), .acc_wr(acc_wr), .acc_idx(acc_idx),
    .acc_way_wen(acc_way_wen), .acc_din(acc_din),
    .acc_grnt(o_grnt[1]), .rd_vld(o_rdv[1]), .tag_idx(o_idx[1]),
    .tag_sel_b(o_sel[1]), .tag_gwen_b(o_gwen[1]), .tag_wen_b(o_wen[1]),
    .tag_din(o_din[1]), .tag_gateclk_en(o_gate[1]), .dbg_state(o_state[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a sweep is "DEPTH cycles, writing index pos" and idle is "grant
  // whatever the pipeline asks for unless an invalidate is pending".
  int depth_of[2] = '{512, 256};
  bit m_busy[2];
  int m_pos[2];
  bit m_init[2];
  bit m_done[2];
  bit m_rdv[2];

  always @(posedge cpuclk or negedge cpurst_b) begin
    for (int i = 0; i < 2; i++) begin
      if (!cpurst_b) begin
        m_busy[i] <= 1'b1;
        m_pos[i]  <= 0;
        m_init[i] <= 1'b1;
        m_done[i] <= 1'b0;
        m_rdv[i]  <= 1'b0;
      end else if (m_busy[i]) begin
        m_rdv[i] <= 1'b0;
        if (m_pos[i] == depth_of[i] - 1) begin
          m_busy[i] <= 1'b0;
          m_pos[i]  <= 0;
          m_done[i] <= !m_init[i];
          m_init[i] <= 1'b0;
        end else begin
          m_pos[i]  <= m_pos[i] + 1;
          m_done[i] <= 1'b0;
        end
      end else begin
        m_rdv[i]  <= acc_vld && !inv_req && !acc_wr;
        m_done[i] <= 1'b0;
        if (inv_req) begin
          m_busy[i] <= 1'b1;
          m_init[i] <= 1'b0;
          m_pos[i]  <= 0;
        end
      end
    end
  end

  // scoreboard compare, once per cycle on the falling edge
  always @(negedge cpuclk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic          e_grnt;
        logic [IW-1:0] e_idx;
        logic          e_sel, e_gwen, e_gate;
        logic [1:0]    e_wen;
        logic [51:0]   e_din;
        string         p;
        p      = (i == 0) ? "d512" : "d256";
        e_grnt = !m_busy[i] && !inv_req && acc_vld;
        if (m_busy[i]) begin
          e_idx = IW'(m_pos[i]); e_sel = 1'b0; e_gwen = 1'b0; e_wen = 2'b00;
          e_din = '0; e_gate = 1'b1;
        end else if (e_grnt) begin
          e_idx = acc_idx; e_sel = 1'b0; e_gwen = !(acc_wr && acc_way_wen != 2'b00);
          e_wen = ~acc_way_wen; e_din = acc_din; e_gate = 1'b1;
        end else begin
          e_idx = acc_idx; e_sel = 1'b1; e_gwen = 1'b1; e_wen = 2'b11;
          e_din = acc_din; e_gate = 1'b0;
        end
        chk({p, ".inv_busy"}, 64'(o_busy[i]), 64'(m_busy[i]));
        chk({p, ".inv_done"}, 64'(o_done[i]), 64'(m_done[i]));
        chk({p, ".acc_grnt"}, 64'(o_grnt[i]), 64'(e_grnt));
        chk({p, ".rd_vld"}, 64'(o_rdv[i]), 64'(m_rdv[i]));
        chk({p, ".tag_idx"}, 64'(o_idx[i]), 64'(e_idx));
        chk({p, ".tag_sel_b"}, 64'(o_sel[i]), 64'(e_sel));
        chk({p, ".tag_gwen_b"}, 64'(o_gwen[i]), 64'(e_gwen));
        chk({p, ".tag_wen_b"}, 64'(o_wen[i]), 64'(e_wen));
        chk({p, ".tag_din"}, 64'(o_din[i]), 64'(e_din));
        chk({p, ".tag_gateclk_en"}, 64'(o_gate[i]), 64'(e_gate));
      end
    end
  end

  // side monitors for the directed literal checks
  int done_pulses = 0;
  int busy256_cycles = 0;
  int max_idx256 = 0;
  always @(negedge cpuclk) begin
    if (!cpurst_b) begin
      busy256_cycles = 0;
      max_idx256 = 0;
    end else begin
      if (o_done[0]) done_pulses++;
      if (o_busy[1]) begin
        busy256_cycles++;
        if (int'(o_idx[1]) > max_idx256) max_idx256 = int'(o_idx[1]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic drive_acc(input logic vld, input logic wr, input logic [IW-1:0] idx,
                           input logic [1:0] wen, input logic [51:0] din);
    acc_vld = vld; acc_wr = wr; acc_idx = idx; acc_way_wen = wen; acc_din = din;
  endtask

  task automatic count_busy_until_idle(output int n);
    n = 0;
    while (o_busy[0] && n < 2000) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses_before;
    drive_acc(1'b1, 1'b0, 9'h033, 2'b11, 52'h1);
    repeat (3) step();
    chk_en = 1'b1;
    @(negedge cpuclk);
    chk("reset.tag_idx", 64'(o_idx[0]), 64'h0);
    chk("reset.tag_gwen_b", 64'(o_gwen[0]), 64'h0);
    chk("reset.rd_vld", 64'(o_rdv[0]), 64'h0);
    step();
    cpurst_b = 1'b1;

    // init sweep with acc_vld held high
    pulses_before = done_pulses;
    count_busy_until_idle(n);
    chk("init.sweep_cycles", 64'(n), 64'd512);
    @(negedge cpuclk);
    chk("init.first_grant", 64'(o_grnt[0]), 64'h1);
    chk("init.no_done", 64'(done_pulses - pulses_before), 64'h0);
    chk("d256.sweep_cycles", 64'(busy256_cycles), 64'd256);
    chk("d256.max_idx", 64'(max_idx256), 64'd255);

    // directed read
    step();
    drive_acc(1'b1, 1'b0, 9'h05A, 2'b11, 52'h0);
    @(negedge cpuclk);
    chk("rd.tag_idx", 64'(o_idx[0]), 64'h05A);
    chk("rd.tag_sel_b", 64'(o_sel[0]), 64'h0);
    chk("rd.tag_gwen_b", 64'(o_gwen[0]), 64'h1);
    step();
    drive_acc(1'b0, 1'b0, 9'h000, 2'b00, 52'h0);
    @(negedge cpuclk);
    chk("rd.rd_vld_next", 64'(o_rdv[0]), 64'h1);
    step();
    @(negedge cpuclk);
    chk("rd.rd_vld_drop", 64'(o_rdv[0]), 64'h0);

    // directed write
    step();
    drive_acc(1'b1, 1'b1, 9'h1FF, 2'b10, 52'hA_BCDE_F012_3456);
    @(negedge cpuclk);
    chk("wr.tag_gwen_b", 64'(o_gwen[0]), 64'h0);
    chk("wr.tag_wen_b", 64'(o_wen[0]), 64'h1);
    chk("wr.tag_din", 64'(o_din[0]), 64'hA_BCDE_F012_3456);
    step();
    drive_acc(1'b1, 1'b0, 9'h010, 2'b00, 52'h0);
    @(negedge cpuclk);
    chk("wr.rd_vld", 64'(o_rdv[0]), 64'h0);

    // invalidate request colliding with an access
    step();
    inv_req = 1'b1;
    @(negedge cpuclk);
    chk("inv.grant_blocked", 64'(o_grnt[0]), 64'h0);
    step();
    n = 0;
    while (!o_done[0] && n < 2000) begin
      if (o_busy[0]) n++;
      step();
    end
    chk("inv.done_seen", 64'(o_done[0]), 64'h1);
    chk("inv.busy_cycles", 64'(n), 64'd512);
    inv_req = 1'b0;
    @(negedge cpuclk);
    chk("inv.grant_resumed", 64'(o_grnt[0]), 64'h1);

    // reset in the middle of a requested sweep
    step();
    inv_req = 1'b1;
    n = 0;
    while (!(o_busy[0] && o_idx[0] == 9'd100) && n < 2000) begin
      n++;
      step();
    end
    chk("mid.reached_100", 64'(o_idx[0]), 64'd100);
    cpurst_b = 1'b0;
    inv_req = 1'b0;
    repeat (2) step();
    cpurst_b = 1'b1;
    pulses_before = done_pulses;
    count_busy_until_idle(n);
    chk("mid.init_cycles", 64'(n), 64'd512);
    step();
    chk("mid.no_done", 64'(done_pulses - pulses_before), 64'h0);

    // randomized traffic with occasional invalidates
    for (int c = 0; c < 4000; c++) begin
      step();
      if (inv_req && o_done[0]) inv_req = ($urandom_range(0, 7) == 0);
      else if (!inv_req) inv_req = ($urandom_range(0, 149) == 0);
      drive_acc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                IW'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
                {20'($urandom), 32'($urandom)});
    end
    inv_req = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_lsu_dcache_tag_ctrl.md
Name: ct_lsu_dcache_tag_ctrl

Overview:
- Upstream control stage for the dcache tag SRAM wrapper. It drives that wrapper's tag_idx, tag_sel_b, tag_gwen_b, tag_wen_b, tag_din and tag_gateclk_en.
- After reset, and on a cp0 invalidate-all request, it sweeps every tag index and writes zeros to both ways.
- Outside a sweep it grants single-cycle read/write accesses from the LSU pipeline. It flags read-data validity one cycle after a granted read, matching the SRAM read latency.

Parameters:
- INDEX_W, 9, tag index width; matches the tag_idx port of the array.
- DEPTH, 512, number of tag entries swept. Use 512 for 64K and 256 for 32K; DEPTH <= 2^INDEX_W.

Ports:
- cpuclk  in  1  core clock.
- cpurst_b  in  1  asynchronous active-low reset.
- inv_req  in  1  invalidate-all request, level; held until inv_done is seen.
- inv_busy  out  1  a sweep (init or requested) is in progress.
- inv_done  out  1  one-cycle pulse; the requested sweep has completed.
- acc_vld  in  1  pipeline access request.
- acc_wr  in  1  1 = write, 0 = read.
- acc_idx  in  INDEX_W  access index.
- acc_way_wen  in  2  active-high way write mask; bit1 = tag bits [51:26], bit0 = tag bits [25:0].
- acc_din  in  52  write data, {way1, way0}.
- acc_grnt  out  1  access accepted this cycle (combinational).
- rd_vld  out  1  tag_dout of the array is valid this cycle.
- tag_idx  out  INDEX_W  array index.
- tag_sel_b  out  1  array chip select, active low.
- tag_gwen_b  out  1  array global write enable, active low.
- tag_wen_b  out  2  per-way write enable, active low.
- tag_din  out  52  array write data.
- tag_gateclk_en  out  1  array clock-gate enable.

Behaviour:
- State: FSM {IDLE, SWEEP}, sweep counter cnt[INDEX_W-1:0], flag init_sweep, registers inv_done and rd_vld.
- Reset (async, cpurst_b=0): state=SWEEP, cnt=0, init_sweep=1, inv_done=0, rd_vld=0.
  - While in reset the combinational outputs show a zero-write to index 0. This is harmless and intended.
- SWEEP, every cycle:
  - Outputs: tag_idx=cnt, tag_sel_b=0, tag_gwen_b=0, tag_wen_b=2'b00, tag_din=0, tag_gateclk_en=1, inv_busy=1, acc_grnt=0.
  - cnt increments each cycle.
  - When cnt==DEPTH-1: cnt is cleared to 0, state goes to IDLE, and inv_done is set for one cycle only if init_sweep==0. init_sweep is cleared in either case.
  - A sweep therefore takes exactly DEPTH cycles.
- IDLE with inv_req=1:
  - Next state is SWEEP with init_sweep=0.
  - inv_req beats acc_vld in the same cycle, so acc_grnt=0.
  - The IDLE cycle itself issues no array access.
- IDLE with inv_req=0:
  - acc_grnt = acc_vld.
  - On grant: tag_idx=acc_idx, tag_sel_b=0, tag_din=acc_din, tag_wen_b=~acc_way_wen, tag_gwen_b=~(acc_wr & |acc_way_wen), tag_gateclk_en=1.
  - A write with acc_way_wen=2'b00 degenerates to a read-cycle with no data update.
- No grant in IDLE: tag_sel_b=1, tag_gwen_b=1, tag_wen_b=2'b11, tag_gateclk_en=0, tag_idx=acc_idx, tag_din=acc_din.
- rd_vld: set on the next edge to (acc_grnt & ~acc_wr), otherwise 0. It is never set by a sweep.
- inv_req and inv_done handshake:
  - The requester drops inv_req in the cycle inv_done=1.
  - inv_req still high in the cycle after inv_done starts a new sweep.
  - inv_req high during the init sweep is serviced by a fresh sweep starting one cycle after the init sweep ends. Only that second sweep pulses inv_done.
- Reset mid-sweep: the current sweep is abandoned and the init sweep restarts from index 0. No inv_done pulse is produced for the abandoned sweep.
- Widths: cnt wraps only via the explicit DEPTH-1 compare. For DEPTH=256 with INDEX_W=9, tag_idx[8]=0 during the sweep.

Test Plan:
- Release reset (DEPTH=512), acc_vld=1 held: tag_idx steps 0..511 with tag_gwen_b=0, tag_wen_b=00, tag_din=0; acc_grnt=0 for 512 cycles; first acc_grnt at cycle 512; inv_done never pulses.
- IDLE, read acc_idx=0x05A: same cycle tag_sel_b=0, tag_gwen_b=1, tag_idx=0x05A; next cycle rd_vld=1, then 0.
- IDLE, write acc_idx=0x1FF, acc_way_wen=2'b10, acc_din=52'hA_BCDE_F012_3456: tag_gwen_b=0, tag_wen_b=2'b01, tag_din=acc_din; rd_vld stays 0.
- IDLE, inv_req=1 and acc_vld=1 in the same cycle: acc_grnt=0; sweep runs 512 cycles with inv_busy=1; inv_done pulses one cycle after the index-511 write; inv_req dropped then gives IDLE with grants resumed.
- Requested sweep, assert cpurst_b=0 at cnt=100: init sweep restarts at index 0; no inv_done after completion; inv_busy=1 for 512 cycles after release.
- DEPTH=256, INDEX_W=9: sweep covers indices 0..255 only with tag_idx[8]=0; IDLE reached after 256 cycles.
